// File: rtl/sr_debounce_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sr_debounce_driver
//  Description : Turns an asynchronous, bouncy push-button or slide-switch
//                input into a clean level that is synchronous to clk_sig.
//                It also produces one-cycle set/reset pulses that drive the
//                s/r inputs of a downstream clocked SR flop directly.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    STABLE_COUNT : consecutive synchronized cycles that must disagree with
//                   the clean level before it flips (1 .. 2^CNT_W-1)
//    CNT_W        : stability counter width; must hold STABLE_COUNT-1
//  Ports
//    clk_sig : system clock, rising-edge active
//    rst     : synchronous, active-high reset
//    raw_in  : asynchronous bouncy input
//    level   : debounced, synchronized level (usable as a D-flop input)
//    s       : one-cycle pulse on a level 0->1 change
//    r       : one-cycle pulse on a level 1->0 change
// ============================================================================
module sr_debounce_driver #(
    parameter int STABLE_COUNT = 4,
    parameter int CNT_W        = 16
) (
    input  logic clk_sig,
    input  logic rst,
    input  logic raw_in,
    output logic level,
    output logic s,
    output logic r
);

    // Terminal count: the flip happens on the edge that sees the counter here.
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(STABLE_COUNT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_s;
    logic             r_r;

    logic             w_differ;
    logic             w_done;

    // Only the second synchronizer stage is allowed past the chain.
    assign w_differ = r_sync2 ^ r_level;
    assign w_done   = w_differ && (r_cnt == c_LAST);

    always_ff @(posedge clk_sig) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            if (!w_differ) begin
                // Any return to the current level discards the partial count.
                r_cnt <= '0;
            end else if (w_done) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
                // The direction of the change picks exactly one pulse, so
                // s and r can never be high together.
                r_s     <= r_sync2;
                r_r     <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign s     = r_s;
    assign r     = r_r;

endmodule
`default_nettype wire

// File: tb/tb_sr_debounce_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_debounce_driver
//  Description : Self-checking bench for sr_debounce_driver.  It runs one
//                instance with STABLE_COUNT=4 and one with STABLE_COUNT=1,
//                both fed by the same stimulus.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_sr_debounce_driver;

    localparam int c_MAXE = 4096;

    logic clk_sig;
    logic rst;
    logic raw_in;
    logic level4, s4, r4;
    logic level1, s1, r1;

    sr_debounce_driver #(.STABLE_COUNT(4), .CNT_W(16)) u_dut4 (
        .clk_sig (clk_sig),
        .rst     (rst),
        .raw_in  (raw_in),
        .level   (level4),
        .s       (s4),
        .r       (r4)
    );

    sr_debounce_driver #(.STABLE_COUNT(1), .CNT_W(4)) u_dut1 (
        .clk_sig (clk_sig),
        .rst     (rst),
        .raw_in  (raw_in),
        .level   (level1),
        .s       (s1),
        .r       (r1)
    );

    initial clk_sig = 1'b0;
    always #5 clk_sig = ~clk_sig;

    int n_checks = 0;
    int n_err    = 0;
    int n        = 0;
    int cur_edge = 0;
    bit use_model4 = 1'b1;

    // Per-edge history of the inputs sampled at each rising edge.
    logic rst_h [c_MAXE];
    logic raw_h [c_MAXE];

    // Reference state, index 0 -> STABLE_COUNT=4, index 1 -> STABLE_COUNT=1.
    logic m_lvl  [2];
    int   m_last [2];
    logic m_s    [2];
    logic m_r    [2];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d actual=%0b required=%0b", nm, cur_edge, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Value the debouncer's decision logic sees at edge j: raw_in from two
    // edges earlier, or 0 if a reset flushed the two-stage chain in between.
    function automatic logic seen(input int j);
        if (j < 2) return 1'b0;
        if (rst_h[j-1] || rst_h[j-2]) return 1'b0;
        return raw_h[j-2];
    endfunction

    // Window rule: the level flips at edge k when the last sc seen values
    // all disagree with the level and all lie after the last change/reset.
    task automatic model_edge(input int idx, input int sc, input int k);
        bit flip;
        m_s[idx] = 1'b0;
        m_r[idx] = 1'b0;
        if (rst_h[k]) begin
            m_lvl[idx]  = 1'b0;
            m_last[idx] = k;
            return;
        end
        flip = 1'b1;
        for (int j = k - sc + 1; j <= k; j++) begin
            if (j <= m_last[idx] || seen(j) == m_lvl[idx]) flip = 1'b0;
        end
        if (flip) begin
            m_lvl[idx]  = ~m_lvl[idx];
            m_s[idx]    = m_lvl[idx];
            m_r[idx]    = ~m_lvl[idx];
            m_last[idx] = k;
        end
    endtask

    task automatic step(input logic rv, input logic dv);
        @(negedge clk_sig);
        rst    = rv;
        raw_in = dv;
        @(posedge clk_sig);
        if (n >= c_MAXE) begin
            $display("FAIL history_overflow edge=%0d", n);
            $fatal(1, "edge history exhausted");
        end
        cur_edge = n;
        rst_h[n] = rv;
        raw_h[n] = dv;
        model_edge(0, 4, n);
        model_edge(1, 1, n);
        n++;
        #1;
        if (use_model4) begin
            chk("m4_level", level4, m_lvl[0]);
            chk("m4_s",     s4,     m_s[0]);
            chk("m4_r",     r4,     m_r[0]);
        end
        chk("m1_level", level1, m_lvl[1]);
        chk("m1_s",     s1,     m_s[1]);
        chk("m1_r",     r1,     m_r[1]);
        chk("excl4", s4 & r4, 1'b0);
        chk("excl1", s1 & r1, 1'b0);
    endtask

    typedef struct {
        logic rst;
        logic raw;
        logic lvl;
        logic s;
        logic r;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int cnt, input logic rv, input logic dv,
                       input logic lv, input logic sv, input logic rrv);
        vec_t v;
        v.rst = rv; v.raw = dv; v.lvl = lv; v.s = sv; v.r = rrv;
        for (int i = 0; i < cnt; i++) vecs.push_back(v);
    endtask

    initial begin
        int s_cnt, r_cnt, s_edge, e0, f0, len;
        logic v;

        rst    = 1'b1;
        raw_in = 1'b1;
        m_lvl[0] = 1'b0; m_lvl[1] = 1'b0;
        m_last[0] = -1;  m_last[1] = -1;
        m_s[0] = 1'b0; m_s[1] = 1'b0; m_r[0] = 1'b0; m_r[1] = 1'b0;

        // Directed vectors for STABLE_COUNT=4.
        add(2, 1, 1, 0, 0, 0);          // reset with raw_in high
        add(5, 0, 1, 0, 0, 0);          // clean rise: edges 0..4
        add(1, 0, 1, 1, 1, 0);          // edge 5: level=1, s pulse
        add(1, 0, 1, 1, 0, 0);          // edge 6: pulse gone
        add(3, 0, 0, 1, 0, 0);          // 3-cycle low glitch while high
        add(5, 0, 1, 1, 0, 0);          // rejected, level stays 1
        add(5, 0, 0, 1, 0, 0);          // clean fall: edges 0..4
        add(1, 0, 0, 0, 0, 1);          // edge 5: level=0, r pulse
        add(1, 0, 0, 0, 0, 0);          // edge 6: pulse gone
        add(3, 0, 1, 0, 0, 0);          // 3-cycle high glitch
        add(6, 0, 0, 0, 0, 0);          // rejected, level stays 0

        use_model4 = 1'b0;
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].raw);
            chk("tbl_level", level4, vecs[i].lvl);
            chk("tbl_s",     s4,     vecs[i].s);
            chk("tbl_r",     r4,     vecs[i].r);
        end
        use_model4 = 1'b1;

        // Bounce: toggle for 10 cycles, then hold high.
        s_cnt = 0; r_cnt = 0; s_edge = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
            if (s4) s_cnt++;
            if (r4) r_cnt++;
        end
        e0 = n;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1);
            if (s4) begin s_cnt++; s_edge = cur_edge; end
            if (r4) r_cnt++;
        end
        chk_int("bounce_s_count", s_cnt, 1);
        chk_int("bounce_s_edge",  s_edge, e0 + 5);
        chk_int("bounce_r_count", r_cnt, 0);

        // Return to level 0, then reset in the middle of a rise (cnt=2).
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        chk("pre_rmc_level", level4, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("rmc_rst_level", level4, 1'b0);
        chk("rmc_rst_s",     s4,     1'b0);
        chk("rmc_rst_r",     r4,     1'b0);
        f0 = n; s_edge = -1; s_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1);
            if (s4) begin s_cnt++; s_edge = cur_edge; end
        end
        chk_int("rmc_s_count", s_cnt, 1);
        chk_int("rmc_s_edge",  s_edge, f0 + 5);
        chk("rmc_level", level4, 1'b1);

        // Reset while the level is high: clears without an r pulse.
        step(1'b1, 1'b1);
        chk("rst_hi_level", level4, 1'b0);
        chk("rst_hi_r",     r4,     1'b0);
        chk("rst_hi_s",     s4,     1'b0);

        // Randomized bursts with occasional resets, checked by the model.
        for (int b = 0; b < 300; b++) begin
            len = $urandom_range(1, 8);
            v   = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, v);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
